// File: rtl/medidor_frecuencia_pkg.sv
// Shared definitions for the frequency meter: period FSM encoding, system clock
// constant shared with the tone divider, and saturating-increment helpers.
package medidor_frecuencia_pkg;

    typedef enum logic [0:0] {
        ESPERA = 1'b0,
        MIDE   = 1'b1
    } estado_t;

    localparam int          FREQ_FPGA = 50000000;
    localparam logic [31:0] SAT32     = 32'hFFFF_FFFF;
    localparam logic [30:0] SAT31     = 31'h7FFF_FFFF;

    function automatic logic [30:0] inc_sat31(input logic [30:0] valor, input logic en);
        logic [30:0] res;
        if (!en) begin
            res = valor;
        end else if (valor == SAT31) begin
            res = valor;
        end else begin
            res = valor + 31'd1;
        end
        return res;
    endfunction

    function automatic logic [31:0] inc_sat32(input logic [31:0] valor);
        logic [31:0] res;
        if (valor == SAT32) begin
            res = valor;
        end else begin
            res = valor + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/medidor_frecuencia_if.sv
// Measurement bus of the frequency meter: the wave to measure and the
// reported frequency, period and silence status.
interface medidor_frecuencia_if;

    logic               sig_in;
    logic signed [31:0] freq;
    logic               freq_valid;
    logic [31:0]        periodo;
    logic               periodo_valid;
    logic               silencio;

    modport master (
        input  sig_in,
        output freq,
        output freq_valid,
        output periodo,
        output periodo_valid,
        output silencio
    );

    modport slave (
        output sig_in,
        input  freq,
        input  freq_valid,
        input  periodo,
        input  periodo_valid,
        input  silencio
    );

endinterface

// File: rtl/medidor_frecuencia_sincronizador_flanco.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle pulse on
// its synchronized rising edge; also used for the push-buttons.
module sincronizador_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic flanco
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain with a delayed copy for edge comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign flanco = s2_r & ~s3_r;

endmodule

// File: rtl/medidor_frecuencia.sv
// Frequency meter: counts rising edges per gate window, measures the period
// between consecutive rising edges and flags silence when edges stop.
module medidor_frecuencia
    import medidor_frecuencia_pkg::*;
#(
    parameter int freq_in        = FREQ_FPGA,
    parameter int GATE_CYCLES    = freq_in,
    parameter int TIMEOUT_CYCLES = FREQ_FPGA
) (
    input  logic                 clk,
    input  logic                 rst,
    medidor_frecuencia_if.master bus
);

    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] TIMEOUT_PRE = 32'(TIMEOUT_CYCLES - 1);

    logic               rise_s;
    logic               gate_fin_s;
    logic               timeout_s;
    logic [30:0]        edge_next_s;

    logic [31:0]        gate_cnt_r;
    logic [30:0]        edge_cnt_r;
    logic signed [31:0] freq_r;
    logic               freq_valid_r;

    estado_t            estado_r;
    logic [31:0]        per_cnt_r;
    logic [31:0]        idle_cnt_r;
    logic [31:0]        periodo_r;
    logic               periodo_valid_r;
    logic               silencio_r;

    sincronizador_flanco u_sinc (
        .clk    (clk),
        .rst    (rst),
        .d      (bus.sig_in),
        .flanco (rise_s)
    );

    // Terminal-cycle and timeout decodes; a rise in the timeout cycle cancels it
    always_comb begin
        gate_fin_s  = (gate_cnt_r == GATE_LAST);
        edge_next_s = inc_sat31(edge_cnt_r, rise_s);
        if (rise_s) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = (idle_cnt_r == TIMEOUT_PRE);
        end
    end

    // Gate window: count edges, report the closing window including its last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt_r   <= 32'd0;
            edge_cnt_r   <= 31'd0;
            freq_r       <= 32'sd0;
            freq_valid_r <= 1'b0;
        end else if (gate_fin_s) begin
            gate_cnt_r   <= 32'd0;
            edge_cnt_r   <= 31'd0;
            freq_r       <= signed'({1'b0, edge_next_s});
            freq_valid_r <= 1'b1;
        end else begin
            gate_cnt_r   <= gate_cnt_r + 32'd1;
            edge_cnt_r   <= edge_next_s;
            freq_valid_r <= 1'b0;
        end
    end

    // Idle counter: cycles since the last rise, held once it reaches the timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= 32'd0;
        end else if (rise_s) begin
            idle_cnt_r <= 32'd0;
        end else if (idle_cnt_r != TIMEOUT_LIM) begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Period FSM: first edge arms the measurement, each later edge reports it
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r        <= ESPERA;
            per_cnt_r       <= 32'd0;
            periodo_r       <= 32'd0;
            periodo_valid_r <= 1'b0;
            silencio_r      <= 1'b1;
        end else begin
            periodo_valid_r <= 1'b0;
            if (timeout_s) begin
                estado_r   <= ESPERA;
                periodo_r  <= 32'd0;
                silencio_r <= 1'b1;
            end else begin
                case (estado_r)
                    ESPERA: begin
                        if (rise_s) begin
                            estado_r  <= MIDE;
                            per_cnt_r <= 32'd1;
                        end else begin
                            estado_r  <= ESPERA;
                        end
                    end
                    MIDE: begin
                        if (rise_s) begin
                            periodo_r       <= per_cnt_r;
                            periodo_valid_r <= 1'b1;
                            per_cnt_r       <= 32'd1;
                            silencio_r      <= 1'b0;
                        end else begin
                            per_cnt_r       <= inc_sat32(per_cnt_r);
                        end
                    end
                    default: begin
                        estado_r <= ESPERA;
                    end
                endcase
            end
        end
    end

    assign bus.freq          = freq_r;
    assign bus.freq_valid    = freq_valid_r;
    assign bus.periodo       = periodo_r;
    assign bus.periodo_valid = periodo_valid_r;
    assign bus.silencio      = silencio_r;

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Scoreboard bench for medidor_frecuencia with a 1000-cycle gate and a
// 500-cycle timeout, driven by a hand-written schedule of rising edges.
module tb_medidor_frecuencia;

    typedef struct {
        int cyc;
        int per;
    } rise_t;

    localparam int END_CYC = 6700;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   freq_q[$];
    int   per_q[$];
    rise_t sched[$];
    int   fcyc[6] = '{1000, 2000, 3000, 4000, 5000, 6603};
    int   fval[6] = '{10, 10, 11, 2, 3, 3};

    medidor_frecuencia_if bus_i ();

    medidor_frecuencia #(
        .GATE_CYCLES    (1000),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic void add_rise(input int c, input int p);
        rise_t r;
        r.cyc = c;
        r.per = p;
        sched.push_back(r);
    endfunction

    // Monitor: compare every valid pulse with the oldest expected value
    always @(negedge clk) begin
        if (bus_i.freq_valid) begin
            if (freq_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL freq_unexpected: got %0d, expected no pulse", bus_i.freq);
            end else begin
                chk("freq", bus_i.freq, freq_q.pop_front());
            end
        end
        if (bus_i.periodo_valid) begin
            if (per_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL periodo_unexpected: got %0d, expected no pulse", bus_i.periodo);
            end else begin
                chk("periodo", bus_i.periodo, per_q.pop_front());
            end
        end
    end

    initial begin
        int p;
        p = 0;
        bus_i.sig_in = 1'b0;

        // Rise cycles (cycle where the detected pulse is high) and expected period (-1: none)
        add_rise(9, -1);
        for (int m = 1; m <= 9; m++) add_rise(9 + 100 * m, 100);
        for (int m = 0; m <= 9; m++) add_rise(1009 + 100 * m, 100);
        add_rise(2049, 140);
        add_rise(2099, 50);
        for (int m = 1; m <= 9; m++) add_rise(2099 + 100 * m, 100);
        add_rise(3099, 100);
        add_rise(3599, 500);
        add_rise(4300, -1);
        add_rise(4400, 100);
        add_rise(4500, 100);
        add_rise(5100, -1);
        for (int m = 1; m <= 4; m++) add_rise(5100 + 100 * m, 100);
        add_rise(5650, -1);
        add_rise(5750, 100);
        add_rise(5850, 100);

        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            bus_i.sig_in = ~bus_i.sig_in;
            chk("reset_state",
                {bus_i.silencio, bus_i.freq_valid, bus_i.periodo_valid,
                 (bus_i.freq == 32'sd0), (bus_i.periodo == 32'd0)},
                5'b10011);
        end
        rst = 1'b0;
        bus_i.sig_in = 1'b0;

        for (int j = 0; j <= END_CYC; j++) begin
            if (j == 5600) rst = 1'b1;
            if (j == 5603) rst = 1'b0;

            if (p < sched.size()) begin
                if (j == sched[p].cyc - 2) begin
                    bus_i.sig_in = 1'b1;
                    if (sched[p].per >= 0) per_q.push_back(sched[p].per);
                end else if (j == sched[p].cyc + 18) begin
                    bus_i.sig_in = 1'b0;
                    p++;
                end
            end

            for (int f = 0; f < 6; f++) begin
                if (j == fcyc[f]) freq_q.push_back(fval[f]);
            end

            case (j)
                8:    chk("silencio_before_first_period", bus_i.silencio, 1);
                110:  chk("silencio_after_first_period", bus_i.silencio, 0);
                1500: chk("freq_hold", bus_i.freq, 10);
                3600: chk("silencio_rise_beats_timeout", bus_i.silencio, 0);
                4099: chk("silencio_before_timeout", bus_i.silencio, 0);
                4100: begin
                    chk("silencio_at_timeout", bus_i.silencio, 1);
                    chk("periodo_cleared_at_timeout", bus_i.periodo, 0);
                end
                4350: chk("silencio_after_one_edge", bus_i.silencio, 1);
                4401: chk("silencio_after_resume", bus_i.silencio, 0);
                5001: begin
                    chk("silencio_second_timeout", bus_i.silencio, 1);
                    chk("periodo_second_timeout", bus_i.periodo, 0);
                end
                5603: begin
                    chk("silencio_mid_reset", bus_i.silencio, 1);
                    chk("freq_mid_reset", bus_i.freq, 0);
                    chk("periodo_mid_reset", bus_i.periodo, 0);
                end
                5751: chk("silencio_after_reset_period", bus_i.silencio, 0);
                6000: chk("freq_partial_window_dropped", bus_i.freq, 0);
                6602: chk("freq_before_new_window", bus_i.freq, 0);
                END_CYC: chk("freq_final_hold", bus_i.freq, 3);
                default: ;
            endcase

            @(posedge clk);
            #1;
        end

        chk("freq_pending_left", freq_q.size(), 0);
        chk("periodo_pending_left", per_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/medidor_frecuencia.md
# medidor_frecuencia

Frequency meter for the music box: the measuring end of the tone-generation path. It takes a square wave from a tone divider output, an external pin, or a loopback and reports two values: rising edges per gate window (Hz when the gate is one second) and the period of the last full cycle in clock cycles. It also raises a silence flag when no edges arrive. Its main uses are self-test of the tone dividers and closed-loop checks of the melody sequencer.

## Interface
- `freq_in`, default 50000000: system clock frequency in Hz (informational; sets the `GATE_CYCLES` default).
- `GATE_CYCLES`, default 50000000: gate window length in clk cycles (one second at 50 MHz).
- `TIMEOUT_CYCLES`, default 50000000: cycles with no rising edge before `silencio` asserts.
- `clk`, input, 1: system clock. Everything is on its rising edge; this is the only clock.
- `rst`, input, 1: reset. Synchronous and active-high.
- `sig_in`, input, 1: square wave to measure. It is asynchronous to `clk`.
- `freq`, output, signed 32: edge count of the last completed gate window (non-negative).
- `freq_valid`, output, 1: one-cycle pulse when `freq` updates.
- `periodo`, output, 32: clk cycles between the last two detected rising edges.
- `periodo_valid`, output, 1: one-cycle pulse when `periodo` updates.
- `silencio`, output, 1: high while no edge has been detected for `TIMEOUT_CYCLES` cycles, and out of reset.

## Operation
- **Synchronizer and edge detect**
  - `sig_in` passes through a two-flop synchronizer (s1, s2), followed by a delayed copy s3.
  - `rise = s2 & ~s3`. All counting uses `rise` only.
  - Input pulses shorter than two clk periods may be lost; this is accepted.
- **Gate path**
  - `gate_cnt` runs 0 .. `GATE_CYCLES`-1 and then wraps.
  - `edge_cnt` increments on `rise` and saturates at 2^31-1.
  - In the terminal cycle (`gate_cnt` = `GATE_CYCLES`-1):
    - `freq` is loaded with `edge_cnt` plus `rise` of that cycle, saturated.
    - `freq_valid` pulses.
    - `edge_cnt` clears to 0.
  - A `rise` in the terminal cycle belongs to the closing window.
- **Period path FSM, state `ESPERA`** (no reference edge yet)
  - On `rise`: move to `MIDE` and load `per_cnt` = 1.
- **Period path FSM, state `MIDE`**
  - `per_cnt` increments each cycle and saturates at 2^32-1.
  - On `rise`:
    - `periodo` ← `per_cnt`.
    - `periodo_valid` pulses.
    - `per_cnt` ← 1.
    - `silencio` ← 0.
  - `periodo` therefore equals the distance in cycles between consecutive `rise` pulses.
- **Timeout and silence**
  - `idle_cnt` clears on `rise` and otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - When it reaches `TIMEOUT_CYCLES`:
    - `silencio` ← 1.
    - `periodo` ← 0 (no `periodo_valid` pulse).
    - FSM returns to `ESPERA`.
  - `silencio` stays 1 until the second `rise` after the timeout, i.e. the first valid period.
  - If a `rise` and the timeout land in the same cycle, the `rise` wins.
- **Reset**
  - Synchronous; may be asserted at any time, including mid-window or mid-period.
  - Clears synchronizer flops, `gate_cnt`, `edge_cnt`, `per_cnt`, `idle_cnt`, and sets FSM to `ESPERA`.
  - Output reset values: `freq`=0, `freq_valid`=0, `periodo`=0, `periodo_valid`=0, `silencio`=1.
  - A partial window or period in progress at reset is discarded and never reported.

## Timing
- `sig_in` rising before clk edge k produces `rise` high in the cycle after edge k+1 (2-cycle latency to detection).
- `periodo`/`periodo_valid` update at the clk edge ending the `rise` cycle: 3 cycles after the input edge.
- `freq_valid` first pulses `GATE_CYCLES` cycles after `rst` deasserts, then every `GATE_CYCLES` cycles.
- Both valid outputs are single-cycle pulses. There is no back-pressure; consumers sample them on the pulse.
- Outputs hold their value between pulses.
- First `periodo_valid` needs two rising edges after reset or after a timeout.
- Paired with the tone divider at count value N, the divider output period is 2(N+1) cycles. Example: 440 Hz gives N=56818, so `periodo`=113638 and `freq` ∈ {439, 440}.

## Structure
- Everything in one module, `medidor_frecuencia`.
- Shared package holds:
  - the `ESPERA`/`MIDE` state encoding;
  - `FREQ_FPGA` = 50000000, shared with the tone divider;
  - `SAT32` and `SAT31` saturation constants.
- One sub-module is natural: `sincronizador_flanco`, containing the 2-flop synchronizer plus the rising-edge pulse. It is reused for the push-buttons.

## Test plan
- **Reset values:** hold `rst` 5 cycles with `sig_in` toggling. All outputs hold their reset values: `silencio`=1, others 0, no valid pulses.
- **Gate count:** `GATE_CYCLES`=1000, `sig_in` period 100 cycles. Every 1000 cycles `freq`=10 with a `freq_valid` pulse; `periodo`=100 on each `periodo_valid`.
- **Divider loopback:** connect the tone divider at 440 Hz with default parameters.
  - Expect `periodo`=113638 on every `periodo_valid`.
  - After 1 s, expect `freq` ∈ {439, 440} and `silencio`=0.
- **Timeout:** `TIMEOUT_CYCLES`=500. Stop `sig_in` after a valid period is reported.
  - Exactly 500 cycles after the last `rise`: `silencio`=1 and `periodo`=0.
  - When toggling resumes, the first `periodo_valid` comes on the second rising edge.
- **Boundary events:**
  - An edge in the gate terminal cycle is counted in the closing window: `freq`=11 when `GATE_CYCLES`=1000 and the edges fall at cycles 99, 199, …, 999 plus one extra.
  - A `rise` coincident with the timeout keeps `silencio`=0.
- **Mid-operation reset:** `rst` asserted at cycle 600 of a 1000-cycle window. After release:
  - `freq` stays 0 until a full new window completes;
  - no `periodo_valid` before two fresh edges.
